// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer. Synchronises the serial line, detects
// the start bit, enables the shared baud counter while a frame is in flight,
// samples each bit on the counter's mid-bit strobe and presents the frame on a
// valid/ready interface with framing, parity and overrun status.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic                 i_read_en,
  input  logic                 i_of_clk,
  output logic                 o_cnt_en,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int             IDX_W       = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic           PAR_ODD_BIT = (PARITY_ODD != 0);
  localparam logic           HAS_PARITY  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   rx_d;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   acc;
  logic                   par_err;
  logic                   read_stb;
  logic                   start_edge;
  logic                   deliver;
  logic                   take;

  // Received parity bit against the running data parity; 1 means mismatch.
  function automatic logic parity_error(input logic acc_in, input logic bit_in);
    return acc_in ^ bit_in ^ PAR_ODD_BIT;
  endfunction

  // The end-of-bit strobe wins if both strobes ever land in one cycle.
  assign read_stb   = i_read_en & ~i_of_clk;
  assign start_edge = rx_d & ~rx_s;
  assign deliver    = (state == STOP) & read_stb;
  assign take       = ~o_valid | i_ready;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; STOP returns to IDLE on the mid-bit strobe so a
  // back-to-back start bit half a bit later is still caught.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_edge) state_nxt = START;
      START: begin
        if (i_of_clk)               state_nxt = DATA;
        else if (i_read_en && rx_s) state_nxt = IDLE;
      end
      DATA:   if (i_of_clk && (bit_idx == LAST_IDX))
                state_nxt = HAS_PARITY ? PARITY : STOP;
      PARITY: if (i_of_clk) state_nxt = STOP;
      STOP:   if (read_stb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter enable and busy are a plain decode of the state register.
  always_comb begin
    o_cnt_en = (state != IDLE);
    o_busy   = (state != IDLE);
  end

  // Bit counter, shift register and parity accumulator for the frame in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
      acc     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (state == START && i_of_clk) begin
        bit_idx <= '0;
        shreg   <= '0;
        acc     <= 1'b0;
        par_err <= 1'b0;
      end
      if (state == DATA) begin
        if (i_of_clk) begin
          if (bit_idx != LAST_IDX) bit_idx <= bit_idx + 1'b1;
        end else if (i_read_en) begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          acc   <= acc ^ rx_s;
        end
      end
      if (state == PARITY && read_stb) par_err <= parity_error(acc, rx_s);
    end
  end

  // Output frame register: load on delivery when the slot is free or being
  // drained this cycle, otherwise drop the new frame and flag overrun.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (deliver) begin
        if (take) begin
          o_data       <= shreg;
          o_frame_err  <= ~rx_s;
          o_parity_err <= HAS_PARITY & par_err;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
